cpu_io_op_sequencer: RTL and testbench

CPU-side controller for the east CPU I/O tile. It accepts one operation from the CPU over a valid/ready request channel and serialises two operands onto the tile's 4-bit OPA/OPB fabric inputs, LSB nibble first. It then collects a two-word result from the tile's RES0/RES1/RES2 outputs and returns it over a valid/ready response channel. Only one operation is in flight at a time; a per-beat timeout protects the CPU against an unconfigured or hung fabric.

---
 rtl/cpu_io_seq_pkg.sv | 27 ++
 rtl/cpu_io_nibble_shifter.sv | 46 ++++
 rtl/cpu_io_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cpu_io_op_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_seq_pkg.sv
// Shared types and constants for the east CPU I/O tile operation sequencer.
package cpu_io_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        COLLECT = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

    localparam int NIBBLE_W    = 4;
    localparam int RES2_STB    = 0;
    localparam int RES2_FLG_HI = 3;
    localparam int RES2_FLG_LO = 1;
    localparam int RES2_FLG_W  = RES2_FLG_HI - RES2_FLG_LO + 1;

    // Width of a counter that indexes n nibbles (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Flag bits carried alongside the result-beat strobe on RES2.
    function automatic logic [RES2_FLG_W-1:0] res2_flags(input logic [NIBBLE_W-1:0] res2);
        return res2[RES2_FLG_HI:RES2_FLG_LO];
    endfunction

endpackage

// File: rtl/cpu_io_nibble_shifter.sv
// Nibble-granular word register. Used either as a loadable right-shift
// register whose low nibble feeds the fabric (OUT_W = NIBBLE_W), or as a
// capture register written one nibble at a time by index (OUT_W = full word).
module cpu_io_nibble_shifter
    import cpu_io_seq_pkg::*;
#(
    parameter int NIBBLES = 8,
    parameter int OUT_W   = NIBBLE_W * NIBBLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [NIBBLE_W*NIBBLES-1:0]    load_data,
    input  logic                           shift,
    input  logic                           cap_en,
    input  logic [idx_width(NIBBLES)-1:0]  cap_idx,
    input  logic [NIBBLE_W-1:0]            cap_nib,
    output logic [OUT_W-1:0]               data
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);

    logic [W-1:0] word;

    // Load has priority; shifting pulls zeros in from the top so the word
    // drains to zero once every nibble has been emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (load) begin
            word <= load_data;
        end else if (shift) begin
            word <= word >> NIBBLE_W;
        end else if (cap_en) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (cap_idx == IDX_W'(n)) begin
                    word[n*NIBBLE_W +: NIBBLE_W] <= cap_nib;
                end
            end
        end
    end

    assign data = word[OUT_W-1:0];

endmodule

// File: rtl/cpu_io_op_sequencer.sv
// CPU-side controller for the east CPU I/O tile: accepts one operation,
// streams both operands to the fabric a nibble per cycle, gathers the
// two-word result strobe by strobe and hands it back to the CPU.
module cpu_io_op_sequencer
    import cpu_io_seq_pkg::*;
#(
    parameter int NIBBLES = 8,
    parameter int TMO_W   = 8
) (
    input  logic                         UserCLK,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_opa,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_opb,
    input  logic [TMO_W-1:0]             req_timeout,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_lo,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_hi,
    output logic [RES2_FLG_W-1:0]        rsp_flags,
    output logic                         rsp_timeout,
    output logic [NIBBLE_W-1:0]          opa_o,
    output logic [NIBBLE_W-1:0]          opb_o,
    output logic                         op_valid,
    input  logic [NIBBLE_W-1:0]          res0_i,
    input  logic [NIBBLE_W-1:0]          res1_i,
    input  logic [NIBBLE_W-1:0]          res2_i
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);

    seq_state_t          state;
    logic [IDX_W-1:0]    beat_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [TMO_W-1:0]    tmo_lim;

    logic                accept;
    logic                strobe;
    logic                shift_en;
    logic                cap_en;
    logic                last_beat;
    logic                tmo_hit;

    assign accept    = (state == IDLE) && req_valid && req_ready;
    assign strobe    = res2_i[RES2_STB];
    assign shift_en  = (state == SEND);
    assign cap_en    = (state == COLLECT) && strobe;
    assign last_beat = (beat_cnt == IDX_W'(NIBBLES - 1));
    // The counter is compared as it would be after this idle cycle, so the
    // operation ends on the cycle the idle count reaches the limit.
    assign tmo_hit   = (tmo_lim != '0) && ((tmo_cnt + TMO_W'(1)) == tmo_lim);

    // Operand A: loaded on accept, shifted once per SEND beat.
    cpu_io_nibble_shifter #(.NIBBLES(NIBBLES), .OUT_W(NIBBLE_W)) u_opa (
        .clk       (UserCLK),
        .reset     (reset),
        .load      (accept),
        .load_data (req_opa),
        .shift     (shift_en),
        .cap_en    (1'b0),
        .cap_idx   ({IDX_W{1'b0}}),
        .cap_nib   ({NIBBLE_W{1'b0}}),
        .data      (opa_o)
    );

    // Operand B: same beat schedule as operand A.
    cpu_io_nibble_shifter #(.NIBBLES(NIBBLES), .OUT_W(NIBBLE_W)) u_opb (
        .clk       (UserCLK),
        .reset     (reset),
        .load      (accept),
        .load_data (req_opb),
        .shift     (shift_en),
        .cap_en    (1'b0),
        .cap_idx   ({IDX_W{1'b0}}),
        .cap_nib   ({NIBBLE_W{1'b0}}),
        .data      (opb_o)
    );

    // Low result word: cleared on accept, one nibble per captured strobe.
    cpu_io_nibble_shifter #(.NIBBLES(NIBBLES), .OUT_W(W)) u_res_lo (
        .clk       (UserCLK),
        .reset     (reset),
        .load      (accept),
        .load_data ({W{1'b0}}),
        .shift     (1'b0),
        .cap_en    (cap_en),
        .cap_idx   (beat_cnt),
        .cap_nib   (res0_i),
        .data      (rsp_lo)
    );

    // High result word: captured in lockstep with the low word.
    cpu_io_nibble_shifter #(.NIBBLES(NIBBLES), .OUT_W(W)) u_res_hi (
        .clk       (UserCLK),
        .reset     (reset),
        .load      (accept),
        .load_data ({W{1'b0}}),
        .shift     (1'b0),
        .cap_en    (cap_en),
        .cap_idx   (beat_cnt),
        .cap_nib   (res1_i),
        .data      (rsp_hi)
    );

    // Operation FSM with beat counter, idle-cycle timeout and flag accumulation.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            op_valid    <= 1'b0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
            beat_cnt    <= '0;
            tmo_cnt     <= '0;
            tmo_lim     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tmo_lim     <= req_timeout;
                        beat_cnt    <= '0;
                        tmo_cnt     <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b0;
                        op_valid    <= 1'b1;
                        state       <= SEND;
                    end else begin
                        req_ready   <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                        op_valid <= 1'b0;
                        state    <= COLLECT;
                    end else begin
                        beat_cnt <= beat_cnt + IDX_W'(1);
                    end
                end
                COLLECT: begin
                    if (strobe) begin
                        rsp_flags <= rsp_flags | res2_flags(res2_i);
                        tmo_cnt   <= '0;
                        if (last_beat) begin
                            rsp_valid   <= 1'b1;
                            rsp_timeout <= 1'b0;
                            state       <= RESP;
                        end else begin
                            beat_cnt <= beat_cnt + IDX_W'(1);
                        end
                    end else if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        beat_cnt  <= '0;
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_io_op_sequencer.sv
// Directed bench for cpu_io_op_sequencer: a table of operations run through
// a small fabric model, plus hand-written reset and no-timeout sequences.
module tb_cpu_io_op_sequencer;

    logic        UserCLK;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic [7:0]  req_timeout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic [2:0]  rsp_flags;
    logic        rsp_timeout;
    logic [3:0]  opa_o;
    logic [3:0]  opb_o;
    logic        op_valid;
    logic [3:0]  res0_i;
    logic [3:0]  res1_i;
    logic [3:0]  res2_i;

    int checks = 0;
    int errors = 0;

    cpu_io_op_sequencer #(.NIBBLES(8), .TMO_W(8)) dut (
        .UserCLK     (UserCLK),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opa     (req_opa),
        .req_opb     (req_opb),
        .req_timeout (req_timeout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_lo      (rsp_lo),
        .rsp_hi      (rsp_hi),
        .rsp_flags   (rsp_flags),
        .rsp_timeout (rsp_timeout),
        .opa_o       (opa_o),
        .opb_o       (opb_o),
        .op_valid    (op_valid),
        .res0_i      (res0_i),
        .res1_i      (res1_i),
        .res2_i      (res2_i)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // One operation and everything the bench expects from it.
    // exp_lat: cycle of first rsp_valid counted from the accept edge.
    typedef struct {
        string       name;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [7:0]  tmo;
        int          gap;
        int          beats;
        logic        send_stb;
        logic [2:0]  f2;
        logic [2:0]  f5;
        int          hold;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic [2:0]  exp_flags;
        logic        exp_tmo;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event within cycle budget", nm);
    endtask

    task automatic drive_beat(input int b, input logic [2:0] flg);
        res0_i = 4'(b);
        res1_i = 4'(15 - b);
        res2_i = {flg, 1'b1};
    endtask

    task automatic clear_fabric();
        res0_i = 4'h0;
        res1_i = 4'h0;
        res2_i = 4'h0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_ctl"}, 64'({req_ready, rsp_valid, op_valid, rsp_timeout, rsp_flags, opa_o, opb_o}), 64'h0);
        chk({nm, "_data"}, {rsp_hi, rsp_lo}, 64'h0);
    endtask

    task automatic apply_reset(input string nm);
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        clear_fabric();
        @(negedge UserCLK);
        @(negedge UserCLK);
        check_all_zero(nm);
        reset = 1'b0;
        @(negedge UserCLK);
        chk({nm, "_ready_after"}, 64'(req_ready), 64'h1);
    endtask

    // Called at a negedge; returns at the negedge of the first SEND cycle.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t,
                            input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge UserCLK);
        end
        if (!ok) begin
            bound_fail({nm, "_req_ready"});
            return;
        end
        req_valid   = 1'b1;
        req_opa     = a;
        req_opb     = b;
        req_timeout = t;
        @(negedge UserCLK);
        req_valid   = 1'b0;
        req_opa     = $urandom;
        req_opb     = $urandom;
        chk({nm, "_ready_drop"}, 64'(req_ready), 64'h0);
    endtask

    function automatic logic [2:0] beat_flag(input vec_t v, input int b);
        if (b == 2) return v.f2;
        if (b == 5) return v.f5;
        return 3'b000;
    endfunction

    // Fabric model answers one cycle after the last operand beat, then
    // strobes every v.gap cycles with res0=k, res1=15-k.
    task automatic do_op(input vec_t v);
        logic [31:0] sa;
        logic [31:0] sb;
        int  nb;
        int  first;
        int  j;
        int  given;
        int  rsp_rel;
        bit  zero_ok;
        bit  stable_ok;
        bit  ok;
        sa = '0; sb = '0; nb = 0; first = -1; j = 0; given = 0; rsp_rel = -1;
        zero_ok = 1'b0; stable_ok = 1'b1;
        start_op(v.opa, v.opb, v.tmo, v.name, ok);
        if (!ok) return;
        for (int rel = 1; rel <= 200; rel++) begin
            if (rsp_valid) begin
                rsp_rel = rel;
                break;
            end
            clear_fabric();
            if (op_valid) begin
                if (nb < 8) begin
                    sa[nb*4 +: 4] = opa_o;
                    sb[nb*4 +: 4] = opb_o;
                end
                if (nb == 0) first = rel;
                nb++;
                if (v.send_stb) begin
                    res0_i = 4'hF;
                    res1_i = 4'hF;
                    res2_i = 4'hF;
                end
            end else if (nb > 0) begin
                if (j == 0) zero_ok = (opa_o == 4'h0) && (opb_o == 4'h0);
                if (j >= 1 && ((j - 1) % v.gap) == 0 && given < v.beats) begin
                    drive_beat(given, beat_flag(v, given));
                    given++;
                end
                j++;
            end
            @(negedge UserCLK);
        end
        clear_fabric();
        chk({v.name, "_opa_beats"}, 64'(sa), 64'(v.opa));
        chk({v.name, "_opb_beats"}, 64'(sb), 64'(v.opb));
        chk({v.name, "_op_valid_win"}, {32'(first), 32'(nb)}, {32'd1, 32'd8});
        chk({v.name, "_collect_ops_zero"}, 64'(zero_ok), 64'h1);
        if (rsp_rel < 0) begin
            bound_fail({v.name, "_rsp_valid"});
            apply_reset({v.name, "_recover"});
            return;
        end
        chk({v.name, "_latency"}, 64'(rsp_rel), 64'(v.exp_lat));
        chk({v.name, "_rsp_lo"}, 64'(rsp_lo), 64'(v.exp_lo));
        chk({v.name, "_rsp_hi"}, 64'(rsp_hi), 64'(v.exp_hi));
        chk({v.name, "_rsp_flags"}, 64'(rsp_flags), 64'(v.exp_flags));
        chk({v.name, "_rsp_timeout"}, 64'(rsp_timeout), 64'(v.exp_tmo));
        for (int h = 0; h < v.hold; h++) begin
            res0_i = 4'($urandom);
            res1_i = 4'($urandom);
            res2_i = 4'($urandom) | 4'h1;
            @(negedge UserCLK);
            if (rsp_lo !== v.exp_lo || rsp_hi !== v.exp_hi || rsp_flags !== v.exp_flags ||
                rsp_timeout !== v.exp_tmo || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        clear_fabric();
        if (v.hold > 0) chk({v.name, "_backpressure_hold"}, 64'(stable_ok), 64'h1);
        rsp_ready = 1'b1;
        @(negedge UserCLK);
        rsp_ready = 1'b0;
        chk({v.name, "_handshake"}, 64'({rsp_valid, req_ready}), 64'h1);
    endtask

    function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] t, input int gap, input int beats,
                                input logic sstb, input logic [2:0] f2, input logic [2:0] f5,
                                input int hold, input logic [31:0] elo, input logic [31:0] ehi,
                                input logic [2:0] efl, input logic etmo, input int lat);
        vec_t v;
        v.name = nm; v.opa = a; v.opb = b; v.tmo = t; v.gap = gap; v.beats = beats;
        v.send_stb = sstb; v.f2 = f2; v.f5 = f5; v.hold = hold;
        v.exp_lo = elo; v.exp_hi = ehi; v.exp_flags = efl; v.exp_tmo = etmo; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        bit ok;
        int given;
        bit seen;
        bit sent;

        vecs[0] = mk("basic",        32'h87654321, 32'h0FEDCBA9, 8'd0, 1, 8, 1'b0, 3'b000, 3'b000, 0,
                     32'h76543210, 32'h89ABCDEF, 3'b000, 1'b0, 18);
        vecs[1] = mk("gap3_flags",   32'hDEADBEEF, 32'h12345678, 8'd3, 3, 8, 1'b0, 3'b001, 3'b100, 0,
                     32'h76543210, 32'h89ABCDEF, 3'b101, 1'b0, 32);
        vecs[2] = mk("timeout5",     32'h11111111, 32'h22222222, 8'd5, 1, 3, 1'b0, 3'b000, 3'b000, 0,
                     32'h00000210, 32'h00000DEF, 3'b000, 1'b1, 18);
        vecs[3] = mk("send_stb_bp",  32'hA5A5A5A5, 32'h5A5A5A5A, 8'd0, 1, 8, 1'b1, 3'b000, 3'b000, 10,
                     32'h76543210, 32'h89ABCDEF, 3'b000, 1'b0, 18);
        vecs[4] = mk("timeout1",     32'hFFFFFFFF, 32'h00000000, 8'd1, 1, 8, 1'b0, 3'b000, 3'b000, 0,
                     32'h00000000, 32'h00000000, 3'b000, 1'b1, 10);
        vecs[5] = mk("timeout2_ok",  32'h0BADF00D, 32'hCAFEF00D, 8'd2, 1, 8, 1'b0, 3'b010, 3'b010, 2,
                     32'h76543210, 32'h89ABCDEF, 3'b010, 1'b0, 18);
        vecs[6] = mk("timeout2_gap", 32'h01234567, 32'h89ABCDEF, 8'd2, 3, 8, 1'b0, 3'b000, 3'b000, 0,
                     32'h00000000, 32'h0000000F, 3'b000, 1'b1, 13);
        vecs[7] = mk("gap2_flag",    32'hFEDCBA98, 32'h76543210, 8'd0, 2, 8, 1'b0, 3'b100, 3'b000, 1,
                     32'h76543210, 32'h89ABCDEF, 3'b100, 1'b0, 25);

        req_valid = 1'b0; req_opa = '0; req_opb = '0; req_timeout = '0;
        rsp_ready = 1'b0;
        clear_fabric();
        apply_reset("por");

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // No timeout: three beats then silence must leave the op pending.
        start_op(32'h13572468, 32'h8642ACE0, 8'd0, "tmo0", ok);
        if (ok) begin
            given = 0; seen = 1'b0; sent = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                if (rsp_valid) seen = 1'b1;
                clear_fabric();
                if (op_valid) sent = 1'b1;
                else if (sent && given < 3) begin
                    drive_beat(given, 3'b000);
                    given++;
                end
                @(negedge UserCLK);
            end
            clear_fabric();
            chk("tmo0_no_rsp", 64'(seen), 64'h0);
        end
        apply_reset("tmo0_rst");

        // Reset during SEND beat 4.
        start_op(32'h87654321, 32'h0FEDCBA9, 8'd0, "rst_send", ok);
        if (ok) begin
            for (int i = 0; i < 4; i++) @(negedge UserCLK);
            chk("rst_send_in_send", 64'({op_valid, opa_o, opb_o}), 64'h15D);
            reset = 1'b1;
            @(negedge UserCLK);
            check_all_zero("rst_send");
            reset = 1'b0;
            @(negedge UserCLK);
            chk("rst_send_ready", 64'(req_ready), 64'h1);
        end

        // Reset during COLLECT beat 3, with a strobe present.
        start_op(32'h87654321, 32'h0FEDCBA9, 8'd0, "rst_coll", ok);
        if (ok) begin
            for (int i = 0; i < 9; i++) @(negedge UserCLK);
            for (int b = 0; b < 3; b++) begin
                drive_beat(b, 3'b111);
                @(negedge UserCLK);
            end
            chk("rst_coll_partial", {rsp_hi, rsp_lo}, {32'h00000DEF, 32'h00000210});
            drive_beat(3, 3'b000);
            reset = 1'b1;
            @(negedge UserCLK);
            clear_fabric();
            check_all_zero("rst_coll");
            reset = 1'b0;
            @(negedge UserCLK);
            chk("rst_coll_ready", 64'(req_ready), 64'h1);
        end

        vecs[0].name = "after_reset";
        do_op(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
